// File: rtl/nanorv32_ibus_arbiter_pkg.sv
// Shared parameters and types for the nanorv32 instruction-bus arbiter:
// data width, master IDs, htrans encodings and the address-phase bundle.
package nanorv32_ibus_arbiter_pkg;

    localparam int   NANORV32_DATA_MSB      = 31;

    localparam logic NANORV32_IBUS_M0       = 1'b0;
    localparam logic NANORV32_IBUS_M1       = 1'b1;

    localparam logic NANORV32_HTRANS_IDLE   = 1'b0;
    localparam logic NANORV32_HTRANS_NONSEQ = 1'b1;

    // Everything a master presents in its address phase, except htrans itself.
    typedef struct packed {
        logic [NANORV32_DATA_MSB:0] addr;
        logic                       write;
        logic [2:0]                 size;
        logic [3:0]                 prot;
    } ibus_aphase_t;

endpackage

// File: rtl/nanorv32_ibus_hold.sv
// One-entry request hold buffer: parks a non-granted master's address phase
// and, for writes, grabs its write data on the following cycle.
module nanorv32_ibus_hold
    import nanorv32_ibus_arbiter_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       capture,
    input  logic                       clear,
    input  ibus_aphase_t               aphase,
    input  logic [NANORV32_DATA_MSB:0] wdata,
    output logic                       valid,
    output ibus_aphase_t               hold_aphase,
    output logic [NANORV32_DATA_MSB:0] hold_wdata
);

    logic                       valid_r;
    logic                       wdata_pend_r;
    ibus_aphase_t               aphase_r;
    logic [NANORV32_DATA_MSB:0] wdata_r;

    // wdata outlives valid so a hold issued right after capture still has its data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r      <= 1'b0;
            wdata_pend_r <= 1'b0;
            aphase_r     <= '0;
            wdata_r      <= '0;
        end else begin
            if (capture) begin
                valid_r  <= 1'b1;
                aphase_r <= aphase;
            end else if (clear) begin
                valid_r  <= 1'b0;
            end
            wdata_pend_r <= capture & aphase.write;
            if (wdata_pend_r) begin
                wdata_r <= wdata;
            end
        end
    end

    assign valid       = valid_r;
    assign hold_aphase = aphase_r;
    assign hold_wdata  = wdata_r;

endmodule

// File: rtl/nanorv32_ibus_arbiter.sv
// Two-master AHB-lite arbiter for the nanorv32 instruction bus with per-master
// hold buffers. Define NANORV32_IBUS_ARB_RR_EN for round-robin; default is M1 priority.
module nanorv32_ibus_arbiter
    import nanorv32_ibus_arbiter_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,

    input  logic [NANORV32_DATA_MSB:0] haddr_m0,
    input  logic                       htrans_m0,
    input  logic                       hwrite_m0,
    input  logic [2:0]                 hsize_m0,
    input  logic [3:0]                 hprot_m0,
    input  logic [NANORV32_DATA_MSB:0] hwdata_m0,
    output logic                       hready_m0,
    output logic [NANORV32_DATA_MSB:0] hrdata_m0,
    output logic                       hresp_m0,

    input  logic [NANORV32_DATA_MSB:0] haddr_m1,
    input  logic                       htrans_m1,
    input  logic                       hwrite_m1,
    input  logic [2:0]                 hsize_m1,
    input  logic [3:0]                 hprot_m1,
    input  logic [NANORV32_DATA_MSB:0] hwdata_m1,
    output logic                       hready_m1,
    output logic [NANORV32_DATA_MSB:0] hrdata_m1,
    output logic                       hresp_m1,

    output logic [NANORV32_DATA_MSB:0] haddr,
    output logic                       htrans,
    output logic                       hwrite,
    output logic [2:0]                 hsize,
    output logic [3:0]                 hprot,
    output logic [NANORV32_DATA_MSB:0] hwdata,
    output logic                       hmaster,
    input  logic [NANORV32_DATA_MSB:0] hrdata,
    input  logic                       hready,
    input  logic                       hresp
);

    ibus_aphase_t               live_m0, live_m1;
    ibus_aphase_t               hold_aphase_m0, hold_aphase_m1;
    ibus_aphase_t               sel_aphase;
    logic                       sel_from_hold;
    logic                       hold_valid_m0, hold_valid_m1;
    logic [NANORV32_DATA_MSB:0] hold_wdata_m0, hold_wdata_m1;
    logic                       req_m0, req_m1;
    logic                       capture_m0, capture_m1;
    logic                       clear_m0, clear_m1;
    logic                       accept;
    logic                       gnt_r, gnt_nxt;
    logic                       dph_valid_r, dph_owner_r, dph_from_hold_r;

    assign live_m0 = {haddr_m0, hwrite_m0, hsize_m0, hprot_m0};
    assign live_m1 = {haddr_m1, hwrite_m1, hsize_m1, hprot_m1};

    assign req_m0 = (hold_valid_m0 || htrans_m0 == NANORV32_HTRANS_NONSEQ)
                    ? NANORV32_HTRANS_NONSEQ : NANORV32_HTRANS_IDLE;
    assign req_m1 = (hold_valid_m1 || htrans_m1 == NANORV32_HTRANS_NONSEQ)
                    ? NANORV32_HTRANS_NONSEQ : NANORV32_HTRANS_IDLE;

    // hready_mN looks only at the slave and the hold, never at htrans_mN
    assign hready_m0 = hready & ~hold_valid_m0;
    assign hready_m1 = hready & ~hold_valid_m1;

    assign capture_m0 = (gnt_r != NANORV32_IBUS_M0) & ~hold_valid_m0
                        & (htrans_m0 == NANORV32_HTRANS_NONSEQ) & hready_m0;
    assign capture_m1 = (gnt_r != NANORV32_IBUS_M1) & ~hold_valid_m1
                        & (htrans_m1 == NANORV32_HTRANS_NONSEQ) & hready_m1;

    assign accept   = hready & (htrans == NANORV32_HTRANS_NONSEQ);
    assign clear_m0 = accept & (gnt_r == NANORV32_IBUS_M0);
    assign clear_m1 = accept & (gnt_r == NANORV32_IBUS_M1);

    nanorv32_ibus_hold u_hold_m0 (
        .clk         (clk),
        .rst         (rst),
        .capture     (capture_m0),
        .clear       (clear_m0),
        .aphase      (live_m0),
        .wdata       (hwdata_m0),
        .valid       (hold_valid_m0),
        .hold_aphase (hold_aphase_m0),
        .hold_wdata  (hold_wdata_m0)
    );

    nanorv32_ibus_hold u_hold_m1 (
        .clk         (clk),
        .rst         (rst),
        .capture     (capture_m1),
        .clear       (clear_m1),
        .aphase      (live_m1),
        .wdata       (hwdata_m1),
        .valid       (hold_valid_m1),
        .hold_aphase (hold_aphase_m1),
        .hold_wdata  (hold_wdata_m1)
    );

    always_comb begin
        sel_aphase    = live_m0;
        sel_from_hold = 1'b0;
        if (gnt_r == NANORV32_IBUS_M1) begin
            sel_aphase    = hold_valid_m1 ? hold_aphase_m1 : live_m1;
            sel_from_hold = hold_valid_m1;
        end else begin
            sel_aphase    = hold_valid_m0 ? hold_aphase_m0 : live_m0;
            sel_from_hold = hold_valid_m0;
        end
    end

    assign htrans  = (gnt_r == NANORV32_IBUS_M1) ? req_m1 : req_m0;
    assign haddr   = sel_aphase.addr;
    assign hwrite  = sel_aphase.write;
    assign hsize   = sel_aphase.size;
    assign hprot   = sel_aphase.prot;
    assign hmaster = gnt_r;

    // On contention every hready cycle is an accept by gnt_r, so "not granted
    // at the last accept" is simply the other master.
    always_comb begin
        gnt_nxt = gnt_r;
        if (req_m0 && req_m1) begin
`ifdef NANORV32_IBUS_ARB_RR_EN
            gnt_nxt = ~gnt_r;
`else
            gnt_nxt = NANORV32_IBUS_M1;
`endif
        end else if (req_m0) begin
            gnt_nxt = NANORV32_IBUS_M0;
        end else if (req_m1) begin
            gnt_nxt = NANORV32_IBUS_M1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_r           <= NANORV32_IBUS_M0;
            dph_valid_r     <= 1'b0;
            dph_owner_r     <= NANORV32_IBUS_M0;
            dph_from_hold_r <= 1'b0;
        end else if (hready) begin
            gnt_r       <= gnt_nxt;
            dph_valid_r <= accept;
            if (accept) begin
                dph_owner_r     <= gnt_r;
                dph_from_hold_r <= sel_from_hold;
            end
        end
    end

    always_comb begin
        hwdata = hwdata_m0;
        if (dph_owner_r == NANORV32_IBUS_M1) begin
            hwdata = dph_from_hold_r ? hold_wdata_m1 : hwdata_m1;
        end else begin
            hwdata = dph_from_hold_r ? hold_wdata_m0 : hwdata_m0;
        end
    end

    assign hrdata_m0 = hrdata;
    assign hrdata_m1 = hrdata;
    assign hresp_m0  = hresp & dph_valid_r & (dph_owner_r == NANORV32_IBUS_M0);
    assign hresp_m1  = hresp & dph_valid_r & (dph_owner_r == NANORV32_IBUS_M1);

endmodule

// File: tb/tb_nanorv32_ibus_arbiter.sv
// Self-checking bench for nanorv32_ibus_arbiter: cycle table plus hand-written
// corner sequences, with a scoreboard of expected slave address phases.
module tb_nanorv32_ibus_arbiter;
    import nanorv32_ibus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] haddr_m0, haddr_m1, hwdata_m0, hwdata_m1;
    logic        htrans_m0, htrans_m1, hwrite_m0, hwrite_m1;
    logic [2:0]  hsize_m0, hsize_m1;
    logic [3:0]  hprot_m0, hprot_m1;
    logic        hready_m0, hready_m1, hresp_m0, hresp_m1;
    logic [31:0] hrdata_m0, hrdata_m1;
    logic [31:0] haddr, hwdata, hrdata;
    logic        htrans, hwrite, hmaster, hready, hresp;
    logic [2:0]  hsize;
    logic [3:0]  hprot;

    int tests_run;
    int tests_failed;

    always #5 clk = ~clk;

    nanorv32_ibus_arbiter dut (
        .clk(clk), .rst(rst),
        .haddr_m0(haddr_m0), .htrans_m0(htrans_m0), .hwrite_m0(hwrite_m0),
        .hsize_m0(hsize_m0), .hprot_m0(hprot_m0), .hwdata_m0(hwdata_m0),
        .hready_m0(hready_m0), .hrdata_m0(hrdata_m0), .hresp_m0(hresp_m0),
        .haddr_m1(haddr_m1), .htrans_m1(htrans_m1), .hwrite_m1(hwrite_m1),
        .hsize_m1(hsize_m1), .hprot_m1(hprot_m1), .hwdata_m1(hwdata_m1),
        .hready_m1(hready_m1), .hrdata_m1(hrdata_m1), .hresp_m1(hresp_m1),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hprot(hprot), .hwdata(hwdata), .hmaster(hmaster),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    // slave returns data derived from the accepted address
    logic [31:0] slv_dph_addr = 32'h0;
    always @(posedge clk) if (hready && htrans) slv_dph_addr <= haddr;
    assign hrdata = slv_dph_addr ^ 32'hA5A5_0000;

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    typedef struct packed {
        logic t0; logic [31:0] a0; logic w0; logic [31:0] d0;
        logic t1; logic [31:0] a1; logic w1; logic [31:0] d1;
        logic rdy; logic rsp;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        push0, push1;
        logic        e_htrans, e_hmaster;
        logic [31:0] e_haddr;
        logic        e_rdy0, e_rdy1;
        logic        chk_rd, rd_master;
        logic [31:0] e_rdata;
    } vec_t;

    typedef struct packed { logic master; logic [31:0] addr; logic write; } sb_t;

    sb_t  sb_q[$];
    sb_t  sb_exp;
    vec_t vecs[10];

    function automatic stim_t mk(input logic t0, input logic [31:0] a0, input logic w0,
                                 input logic [31:0] d0, input logic t1, input logic [31:0] a1,
                                 input logic w1, input logic [31:0] d1,
                                 input logic rdy, input logic rsp);
        stim_t s;
        s.t0 = t0; s.a0 = a0; s.w0 = w0; s.d0 = d0;
        s.t1 = t1; s.a1 = a1; s.w1 = w1; s.d1 = d1;
        s.rdy = rdy; s.rsp = rsp;
        return s;
    endfunction

    function automatic stim_t mk_rd(input logic t0, input logic [31:0] a0,
                                    input logic t1, input logic [31:0] a1, input logic rdy);
        return mk(t0, a0, 1'b0, 32'h0, t1, a1, 1'b0, 32'h0, rdy, 1'b0);
    endfunction

    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #1;
        htrans_m0 = s.t0; haddr_m0 = s.a0; hwrite_m0 = s.w0; hwdata_m0 = s.d0;
        htrans_m1 = s.t1; haddr_m1 = s.a1; hwrite_m1 = s.w1; hwdata_m1 = s.d1;
        hready = s.rdy; hresp = s.rsp;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp_v);
        end
    endtask

    task automatic pushExpect(input logic m, input logic [31:0] a, input logic w);
        sb_q.push_back({m, a, w});
    endtask

    always @(negedge clk) begin
        if (!rst && hready && htrans) begin
            if (sb_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL sb_unexpected: got transfer to 0x%08h, want none", haddr);
            end else begin
                sb_exp = sb_q.pop_front();
                checkOutput("sb_hmaster", 32'(hmaster), 32'(sb_exp.master));
                checkOutput("sb_haddr", haddr, sb_exp.addr);
                checkOutput("sb_hwrite", 32'(hwrite), 32'(sb_exp.write));
            end
        end
    end

    initial begin
        int          cnt0, cnt1;
        logic [3:0]  exp_hm;

        tests_run = 0;
        tests_failed = 0;
        hsize_m0 = 3'b010; hprot_m0 = 4'h3;
        hsize_m1 = 3'b010; hprot_m1 = 4'h1;
        htrans_m0 = 0; haddr_m0 = 0; hwrite_m0 = 0; hwdata_m0 = 0;
        htrans_m1 = 0; haddr_m1 = 0; hwrite_m1 = 0; hwdata_m1 = 0;
        hready = 1'b1; hresp = 1'b1;
        rst = 1'b1;

        #2;
        checkOutput("reset htrans", 32'(htrans), 32'd0);
        checkOutput("reset hmaster", 32'(hmaster), 32'd0);
        checkOutput("reset hready_m0", 32'(hready_m0), 32'd1);
        checkOutput("reset hready_m1", 32'(hready_m1), 32'd1);
        checkOutput("reset hresp_m0", 32'(hresp_m0), 32'd0);
        hresp = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        //            stimulus                                 p0 p1 htr hm haddr        r0 r1 chk rm rdata
        vecs[0] = '{mk_rd(1, 32'h100, 0, 32'h0,    1),          1, 0, 1, 0, 32'h100,     1, 1, 0, 0, 32'h0};
        vecs[1] = '{mk_rd(1, 32'h104, 0, 32'h0,    1),          1, 0, 1, 0, 32'h104,     1, 1, 1, 0, slave_data(32'h100)};
        vecs[2] = '{mk_rd(1, 32'h108, 0, 32'h0,    1),          1, 0, 1, 0, 32'h108,     1, 1, 1, 0, slave_data(32'h104)};
        vecs[3] = '{mk_rd(0, 32'h10C, 0, 32'h0,    1),          0, 0, 0, 0, 32'h10C,     1, 1, 1, 0, slave_data(32'h108)};
        vecs[4] = '{mk_rd(1, 32'h200, 1, 32'h8000, 1),          1, 1, 1, 0, 32'h200,     1, 1, 0, 0, 32'h0};
        vecs[5] = '{mk_rd(0, 32'h0,   0, 32'h0,    1),          0, 0, 1, 1, 32'h8000,    1, 0, 1, 0, slave_data(32'h200)};
        vecs[6] = '{mk_rd(0, 32'h0,   0, 32'h0,    1),          0, 0, 0, 1, 32'h0,       1, 1, 1, 1, slave_data(32'h8000)};
        vecs[7] = '{mk_rd(1, 32'h300, 0, 32'h80F0, 1),          1, 0, 0, 1, 32'h80F0,    1, 1, 0, 0, 32'h0};
        vecs[8] = '{mk_rd(0, 32'h0,   0, 32'h0,    1),          0, 0, 1, 0, 32'h300,     0, 1, 0, 0, 32'h0};
        vecs[9] = '{mk_rd(0, 32'h0,   0, 32'h0,    1),          0, 0, 0, 0, 32'h0,       1, 1, 1, 0, slave_data(32'h300)};

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].push0) pushExpect(1'b0, vecs[i].s.a0, 1'b0);
            if (vecs[i].push1) pushExpect(1'b1, vecs[i].s.a1, 1'b0);
            applyStimulus(vecs[i].s);
            #3;
            checkOutput($sformatf("vec%0d htrans", i), 32'(htrans), 32'(vecs[i].e_htrans));
            checkOutput($sformatf("vec%0d hmaster", i), 32'(hmaster), 32'(vecs[i].e_hmaster));
            checkOutput($sformatf("vec%0d haddr", i), haddr, vecs[i].e_haddr);
            checkOutput($sformatf("vec%0d hprot", i), 32'(hprot),
                        vecs[i].e_hmaster ? 32'h1 : 32'h3);
            checkOutput($sformatf("vec%0d hready_m0", i), 32'(hready_m0), 32'(vecs[i].e_rdy0));
            checkOutput($sformatf("vec%0d hready_m1", i), 32'(hready_m1), 32'(vecs[i].e_rdy1));
            if (vecs[i].chk_rd)
                checkOutput($sformatf("vec%0d hrdata", i),
                            vecs[i].rd_master ? hrdata_m1 : hrdata_m0, vecs[i].e_rdata);
        end

        // wait states during M1's data phase freeze grant, holds and address
        pushExpect(1'b1, 32'h8010, 1'b0);
        applyStimulus(mk_rd(0, 32'h0, 1, 32'h8010, 1));
        #3 checkOutput("ws capture hready_m1", 32'(hready_m1), 32'd1);
        pushExpect(1'b1, 32'h8014, 1'b0);
        applyStimulus(mk_rd(0, 32'h0, 1, 32'h8014, 1));
        #3;
        checkOutput("ws held haddr", haddr, 32'h8010);
        checkOutput("ws held hready_m1", 32'(hready_m1), 32'd0);
        pushExpect(1'b0, 32'h400, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(mk_rd(1, 32'h400, 1, 32'h8014, 0));
            #3;
            checkOutput($sformatf("ws%0d hmaster", k), 32'(hmaster), 32'd1);
            checkOutput($sformatf("ws%0d haddr", k), haddr, 32'h8014);
            checkOutput($sformatf("ws%0d hready_m0", k), 32'(hready_m0), 32'd0);
            checkOutput($sformatf("ws%0d hready_m1", k), 32'(hready_m1), 32'd0);
        end
        applyStimulus(mk_rd(1, 32'h400, 1, 32'h8014, 1));
        #3;
        checkOutput("ws release haddr", haddr, 32'h8014);
        checkOutput("ws release hready_m1", 32'(hready_m1), 32'd1);
        repeat (3) applyStimulus(mk_rd(0, 32'h0, 0, 32'h0, 1));

        // both masters request every cycle, addresses advance on their hready
`ifdef NANORV32_IBUS_ARB_RR_EN
        exp_hm = 4'b1010;
        pushExpect(0, 32'h500, 0); pushExpect(1, 32'h9000, 0); pushExpect(0, 32'h504, 0);
        pushExpect(1, 32'h9004, 0); pushExpect(0, 32'h508, 0);
`else
        exp_hm = 4'b1110;
        pushExpect(0, 32'h500, 0); pushExpect(1, 32'h9000, 0); pushExpect(1, 32'h9004, 0);
        pushExpect(1, 32'h9008, 0); pushExpect(0, 32'h504, 0);
`endif
        cnt0 = 0;
        cnt1 = 0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(mk_rd(1, 32'h500 + 32'(4 * cnt0), 1, 32'h9000 + 32'(4 * cnt1), 1));
            #3;
            checkOutput($sformatf("policy c%0d hmaster", c), 32'(hmaster), 32'(exp_hm[c]));
            if (hready_m0) cnt0++;
            if (hready_m1) cnt1++;
        end
        repeat (3) applyStimulus(mk_rd(0, 32'h0, 0, 32'h0, 1));

        // held write from M1 with an error response, followed by a held M0 read
        pushExpect(1'b1, 32'h8004, 1'b1);
        applyStimulus(mk(0, 32'h0, 0, 32'h0, 1, 32'h8004, 1, 32'h0, 1, 0));
        #3 checkOutput("wr capture hready_m1", 32'(hready_m1), 32'd1);
        applyStimulus(mk(0, 32'h0, 0, 32'h1111_1111, 0, 32'h0, 0, 32'hDEAD_BEEF, 1, 0));
        #3;
        checkOutput("wr issue hmaster", 32'(hmaster), 32'd1);
        checkOutput("wr issue haddr", haddr, 32'h8004);
        pushExpect(1'b0, 32'h600, 1'b0);
        applyStimulus(mk(1, 32'h600, 0, 32'h1111_1111, 0, 32'h0, 0, 32'h0BAD_F00D, 0, 1));
        #3;
        checkOutput("err1 hwdata", hwdata, 32'hDEAD_BEEF);
        checkOutput("err1 hresp_m1", 32'(hresp_m1), 32'd1);
        checkOutput("err1 hresp_m0", 32'(hresp_m0), 32'd0);
        applyStimulus(mk(1, 32'h600, 0, 32'h1111_1111, 0, 32'h0, 0, 32'h0BAD_F00D, 1, 1));
        #3;
        checkOutput("err2 hwdata", hwdata, 32'hDEAD_BEEF);
        checkOutput("err2 hresp_m1", 32'(hresp_m1), 32'd1);
        checkOutput("err2 hresp_m0", 32'(hresp_m0), 32'd0);
        applyStimulus(mk(0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 1));
        #3;
        checkOutput("after err hmaster", 32'(hmaster), 32'd0);
        checkOutput("after err haddr", haddr, 32'h600);
        checkOutput("after err hresp_m1", 32'(hresp_m1), 32'd0);
        applyStimulus(mk_rd(0, 32'h0, 0, 32'h0, 1));

        // reset pulse while M1's hold is full
        applyStimulus(mk_rd(0, 32'h0, 1, 32'h8100, 1));
        #3 checkOutput("rst capture hready_m1", 32'(hready_m1), 32'd1);
        applyStimulus(mk_rd(0, 32'h0, 0, 32'h0, 0));
        #3;
        checkOutput("rst pre hmaster", 32'(hmaster), 32'd1);
        checkOutput("rst pre haddr", haddr, 32'h8100);
        @(negedge clk);
        #1;
        rst = 1'b1;
        hready = 1'b1;
        #1;
        checkOutput("rst mid htrans", 32'(htrans), 32'd0);
        checkOutput("rst mid hmaster", 32'(hmaster), 32'd0);
        checkOutput("rst mid hready_m1", 32'(hready_m1), 32'd1);
        hready = 1'b0;
        #1 checkOutput("rst mid hready_m1 low", 32'(hready_m1), 32'd0);
        hready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(mk_rd(0, 32'h0, 0, 32'h0, 1));
        #3;
        checkOutput("post rst htrans", 32'(htrans), 32'd0);
        checkOutput("post rst hready_m1", 32'(hready_m1), 32'd1);
        repeat (2) applyStimulus(mk_rd(0, 32'h0, 0, 32'h0, 1));

        #3 checkOutput("sb drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
